// File: rtl/ram_scan_reader.sv
// ram_scan_reader: read-side sequencer for a small synchronous-read RAM.
// Sweeps rd_addr through every word, paced by a tick counter or single-step
// pulses, and registers each word read back for the HEX display.
//
// Optional feature (macro SCAN_WRITE_REFRESH_EN): adds wr_en/wr_addr so that a
// write to the currently displayed address triggers a re-read of that word.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ISSUE   | rd_addr stable; the RAM samples it at this edge
// CAPTURE | RAM q valid; latch it into disp_*; restart tick count
// HOLD    | display word; wait for tick terminal count or step

module ram_scan_reader #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 3,
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              step,
`ifdef SCAN_WRITE_REFRESH_EN
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
`endif
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              wrap
);

  localparam int                TICK_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

  typedef enum logic [1:0] {
    S_ISSUE   = 2'd0,
    S_CAPTURE = 2'd1,
    S_HOLD    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]   disp_addr_q, disp_addr_d;
  logic [DATA_W-1:0]   disp_data_q, disp_data_d;
  logic                disp_valid_q, disp_valid_d;
  logic                wrap_q, wrap_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  // set while the current ISSUE/CAPTURE pass is a re-read of the same word,
  // so CAPTURE keeps the tick count instead of restarting it
  logic                refresh_q, refresh_d;

  logic tick_done;
  logic advance;
  logic refresh;

  // Advance / refresh decisions, only meaningful while holding a word
  always_comb begin
    tick_done = (tick_q == TICK_LAST);
    advance   = (state_q == S_HOLD) && (step || (enable && tick_done));
`ifdef SCAN_WRITE_REFRESH_EN
    refresh   = (state_q == S_HOLD) && wr_en && (wr_addr == disp_addr_q) && !advance;
`else
    refresh   = 1'b0;
`endif
  end

  // State register
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_ISSUE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ISSUE:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_HOLD;
      S_HOLD:    if (advance || refresh) state_d = S_ISSUE;
      default:   state_d = S_ISSUE;
    endcase
  end

  // Datapath next values per state
  always_comb begin
    rd_addr_d    = rd_addr_q;
    disp_addr_d  = disp_addr_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = disp_valid_q;
    wrap_d       = 1'b0;
    tick_d       = tick_q;
    refresh_d    = refresh_q;
    case (state_q)
      S_CAPTURE: begin
        disp_data_d  = rd_data;
        disp_addr_d  = rd_addr_q;
        disp_valid_d = 1'b1;
        if (!refresh_q) tick_d = '0;
        refresh_d    = 1'b0;
      end
      S_HOLD: begin
        if (advance) begin
          rd_addr_d = rd_addr_q + 1'b1;
          wrap_d    = (rd_addr_q == ADDR_MAX);
          tick_d    = '0;
        end else begin
          if (enable && !tick_done) tick_d = tick_q + 1'b1;
          if (refresh) refresh_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_q    <= '0;
      disp_addr_q  <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      wrap_q       <= 1'b0;
      tick_q       <= '0;
      refresh_q    <= 1'b0;
    end else begin
      rd_addr_q    <= rd_addr_d;
      disp_addr_q  <= disp_addr_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      wrap_q       <= wrap_d;
      tick_q       <= tick_d;
      refresh_q    <= refresh_d;
    end
  end

  assign rd_addr    = rd_addr_q;
  assign disp_addr  = disp_addr_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_ram_scan_reader.sv
// Bench for ram_scan_reader with TICK_CYCLES=4 and a behavioural sync-read RAM
// preloaded with mem[i]=(i*3)%8. Displayed words are checked against a queue
// of expected (addr, data) pairs filled when stimulus is driven.

module tb_ram_scan_reader;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 3;
  localparam int TICK   = 4;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic              step = 1'b0;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              wrap;

  logic              ram_we = 1'b0;
  logic [ADDR_W-1:0] ram_wa = '0;
  logic [DATA_W-1:0] ram_wd = '0;
  logic [DATA_W-1:0] mem [DEPTH];
`ifdef SCAN_WRITE_REFRESH_EN
  logic              dut_wr_sel = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_wd;
    rd_data <= mem[rd_addr];
  end

  ram_scan_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TICK_CYCLES(TICK)
  ) dut (
    .CLOCK_50  (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .step      (step),
`ifdef SCAN_WRITE_REFRESH_EN
    .wr_en     (ram_we & dut_wr_sel),
    .wr_addr   (ram_wa),
`endif
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .disp_addr (disp_addr),
    .disp_data (disp_data),
    .disp_valid(disp_valid),
    .wrap      (wrap)
  );

  function automatic logic [DATA_W-1:0] golden(input int a);
    return DATA_W'((a * 3) % 8);
  endfunction

  // waits until disp_addr changes; cycles = -1 on timeout
  task automatic wait_disp_change(input int budget, output int cycles);
    logic [ADDR_W-1:0] start_addr;
    start_addr = disp_addr;
    cycles = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (disp_addr !== start_addr) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    enable  = 1'b0;
    reset_n = 1'b0;
    #1;
    n_checks++; if (rd_addr !== 5'd0) begin n_errors++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr); end
    n_checks++; if (disp_addr !== 5'd0) begin n_errors++; $display("FAIL reset_disp_addr: got %0d expected 0", disp_addr); end
    n_checks++; if (disp_data !== 3'd0) begin n_errors++; $display("FAIL reset_disp_data: got %0d expected 0", disp_data); end
    n_checks++; if (disp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_disp_valid: got %0b expected 0", disp_valid); end
    n_checks++; if (wrap !== 1'b0) begin n_errors++; $display("FAIL reset_wrap: got %0b expected 0", wrap); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (disp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid_edge1: got %0b expected 0", disp_valid); end
    @(posedge clk); #1;
    n_checks++; if (disp_valid !== 1'b1) begin n_errors++; $display("FAIL reset_valid_edge2: got %0b expected 1", disp_valid); end
    n_checks++; if (disp_addr !== 5'd0) begin n_errors++; $display("FAIL reset_first_addr: got %0d expected 0", disp_addr); end
    n_checks++; if (disp_data !== 3'd0) begin n_errors++; $display("FAIL reset_first_data: got %0d expected 0", disp_data); end
  endtask

  task automatic test_sweep();
    logic [ADDR_W-1:0] prev_rd, last_disp;
    int   last_cyc, wraps;
    bit   exp_wrap;
    exp_t e;
    enable = 1'b1;
    for (int k = 1; k <= 2 * DEPTH; k++) begin
      e.addr = ADDR_W'(k % DEPTH);
      e.data = golden(k % DEPTH);
      exp_q.push_back(e);
    end
    prev_rd   = rd_addr;
    last_disp = disp_addr;
    last_cyc  = 0;
    wraps     = 0;
    for (int cyc = 1; cyc <= 500; cyc++) begin
      @(posedge clk); #1;
      exp_wrap = (prev_rd == 5'd31) && (rd_addr == 5'd0);
      if (wrap === 1'b1) wraps++;
      n_checks++;
      if (wrap !== exp_wrap) begin
        n_errors++;
        $display("FAIL sweep_wrap: got %0b expected %0b (rd_addr %0d->%0d)", wrap, exp_wrap, prev_rd, rd_addr);
      end
      prev_rd = rd_addr;
      if (disp_addr !== last_disp) begin
        e = exp_q.pop_front();
        n_checks++; if (disp_addr !== e.addr) begin n_errors++; $display("FAIL sweep_addr: got %0d expected %0d", disp_addr, e.addr); end
        n_checks++; if (disp_data !== e.data) begin n_errors++; $display("FAIL sweep_data: got %0d expected %0d at addr %0d", disp_data, e.data, e.addr); end
        n_checks++; if (cyc - last_cyc != TICK + 2) begin n_errors++; $display("FAIL sweep_period: got %0d expected %0d", cyc - last_cyc, TICK + 2); end
        last_cyc  = cyc;
        last_disp = disp_addr;
        if (exp_q.size() == 0) break;
      end
    end
    enable = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL sweep_timeout: got %0d words left expected 0", exp_q.size());
      exp_q.delete();
    end
    n_checks++; if (wraps != 2) begin n_errors++; $display("FAIL sweep_wrap_count: got %0d expected 2", wraps); end
  endtask

  task automatic test_step();
    int   c;
    exp_t e;
    for (int k = 1; k <= 2; k++) begin
      e.addr = ADDR_W'(k); e.data = golden(k); exp_q.push_back(e);
      step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      n_checks++; if (rd_addr !== ADDR_W'(k)) begin n_errors++; $display("FAIL step_rd_addr: got %0d expected %0d", rd_addr, k); end
      wait_disp_change(10, c);
      e = exp_q.pop_front();
      n_checks++; if (c != 2) begin n_errors++; $display("FAIL step_latency: got %0d expected 2", c); end
      n_checks++; if (disp_addr !== e.addr) begin n_errors++; $display("FAIL step_addr: got %0d expected %0d", disp_addr, e.addr); end
      n_checks++; if (disp_data !== e.data) begin n_errors++; $display("FAIL step_data: got %0d expected %0d", disp_data, e.data); end
    end
    // step held through HOLD and the following ISSUE: only one advance
    e.addr = 5'd3; e.data = golden(3); exp_q.push_back(e);
    step = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    step = 1'b0;
    @(posedge clk); #1;
    e = exp_q.pop_front();
    n_checks++; if (disp_addr !== e.addr) begin n_errors++; $display("FAIL step3_addr: got %0d expected %0d", disp_addr, e.addr); end
    n_checks++; if (disp_data !== e.data) begin n_errors++; $display("FAIL step3_data: got %0d expected %0d", disp_data, e.data); end
    repeat (10) @(posedge clk);
    #1;
    n_checks++; if (rd_addr !== 5'd3) begin n_errors++; $display("FAIL step_issue_ignored: got rd_addr %0d expected 3", rd_addr); end
    n_checks++; if (disp_addr !== 5'd3) begin n_errors++; $display("FAIL step_hold_addr: got %0d expected 3", disp_addr); end
  endtask

  task automatic test_freeze();
    int   c;
    exp_t e;
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    enable = 1'b0;
    n_checks++; if (rd_addr !== 5'd3) begin n_errors++; $display("FAIL freeze_early: got rd_addr %0d expected 3", rd_addr); end
    repeat (10) @(posedge clk);
    #1;
    n_checks++; if (rd_addr !== 5'd3) begin n_errors++; $display("FAIL freeze_hold: got rd_addr %0d expected 3", rd_addr); end
    enable = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (rd_addr !== 5'd3) begin n_errors++; $display("FAIL freeze_resume1: got rd_addr %0d expected 3", rd_addr); end
    @(posedge clk); #1;
    enable = 1'b0;
    n_checks++; if (rd_addr !== 5'd4) begin n_errors++; $display("FAIL freeze_resume2: got rd_addr %0d expected 4", rd_addr); end
    e.addr = 5'd4; e.data = golden(4); exp_q.push_back(e);
    wait_disp_change(6, c);
    e = exp_q.pop_front();
    n_checks++; if (c != 2) begin n_errors++; $display("FAIL freeze_latency: got %0d expected 2", c); end
    n_checks++; if (disp_data !== e.data) begin n_errors++; $display("FAIL freeze_data: got %0d expected %0d", disp_data, e.data); end
  endtask

`ifdef SCAN_WRITE_REFRESH_EN
  task automatic test_refresh();
    int c;
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    wait_disp_change(6, c);
    n_checks++; if (disp_addr !== 5'd5 || disp_data !== 3'd7) begin n_errors++; $display("FAIL refresh_setup: got addr %0d data %0d expected 5/7", disp_addr, disp_data); end
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    enable = 1'b0;
    ram_wa = 5'd5; ram_wd = 3'd6; ram_we = 1'b1; dut_wr_sel = 1'b1;
    @(posedge clk); #1;
    ram_we = 1'b0; dut_wr_sel = 1'b0;
    n_checks++; if (rd_addr !== 5'd5 || wrap !== 1'b0) begin n_errors++; $display("FAIL refresh_issue: got rd_addr %0d wrap %0b expected 5/0", rd_addr, wrap); end
    @(posedge clk); #1;
    n_checks++; if (disp_data !== 3'd7) begin n_errors++; $display("FAIL refresh_no_blank: got %0d expected 7", disp_data); end
    @(posedge clk); #1;
    n_checks++; if (disp_data !== 3'd6) begin n_errors++; $display("FAIL refresh_data: got %0d expected 6", disp_data); end
    n_checks++; if (disp_addr !== 5'd5 || wrap !== 1'b0) begin n_errors++; $display("FAIL refresh_addr: got addr %0d wrap %0b expected 5/0", disp_addr, wrap); end
    // change mem[5] behind the DUT's back, then write a different address
    ram_wa = 5'd5; ram_wd = 3'd1; ram_we = 1'b1;
    @(posedge clk); #1;
    ram_wa = 5'd4; ram_wd = 3'd2; dut_wr_sel = 1'b1;
    @(posedge clk); #1;
    ram_we = 1'b0; dut_wr_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (disp_data !== 3'd6) begin n_errors++; $display("FAIL refresh_other_addr: got %0d expected 6", disp_data); end
    ram_wa = 5'd5; ram_wd = golden(5); ram_we = 1'b1;
    @(posedge clk); #1;
    ram_wa = 5'd4; ram_wd = golden(4);
    @(posedge clk); #1;
    ram_we = 1'b0;
    // tick count from before the refresh must survive it
    enable = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (rd_addr !== 5'd5) begin n_errors++; $display("FAIL refresh_tick1: got rd_addr %0d expected 5", rd_addr); end
    @(posedge clk); #1;
    enable = 1'b0;
    n_checks++; if (rd_addr !== 5'd6) begin n_errors++; $display("FAIL refresh_tick2: got rd_addr %0d expected 6", rd_addr); end
    wait_disp_change(6, c);
    n_checks++; if (disp_addr !== 5'd6 || disp_data !== golden(6)) begin n_errors++; $display("FAIL refresh_next: got addr %0d data %0d expected 6/%0d", disp_addr, disp_data, golden(6)); end
  endtask
`endif

  task automatic test_coincident();
    int   c;
    bit   found;
    exp_t e;
    enable = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (disp_addr === 5'd7) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL coinc_reach7: got disp_addr %0d expected 7", disp_addr);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (rd_addr !== 5'd7) begin n_errors++; $display("FAIL coinc_pre: got rd_addr %0d expected 7", rd_addr); end
    step = 1'b1;
    @(posedge clk); #1;
    step   = 1'b0;
    enable = 1'b0;
    n_checks++; if (rd_addr !== 5'd8) begin n_errors++; $display("FAIL coinc_single: got rd_addr %0d expected 8", rd_addr); end
    e.addr = 5'd8; e.data = golden(8); exp_q.push_back(e);
    wait_disp_change(6, c);
    e = exp_q.pop_front();
    n_checks++; if (disp_addr !== e.addr) begin n_errors++; $display("FAIL coinc_addr: got %0d expected %0d", disp_addr, e.addr); end
    n_checks++; if (disp_data !== e.data) begin n_errors++; $display("FAIL coinc_data: got %0d expected %0d", disp_data, e.data); end
    repeat (12) @(posedge clk);
    #1;
    n_checks++; if (rd_addr !== 5'd8 || disp_addr !== 5'd8) begin n_errors++; $display("FAIL coinc_settle: got rd %0d disp %0d expected 8/8", rd_addr, disp_addr); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram_wa = ADDR_W'(i);
      ram_wd = golden(i);
      ram_we = 1'b1;
      @(posedge clk); #1;
    end
    ram_we  = 1'b0;
    reset_n = 1'b1;
    enable  = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    test_reset();
    test_sweep();
    test_step();
    test_freeze();
`ifdef SCAN_WRITE_REFRESH_EN
    test_refresh();
`endif
    test_coincident();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
